// File: rtl/orgate_if.sv
// ----------------------------------------------------------------------------
// orgate_if -- operand/result bundle for the orgate bitwise-OR unit.
//
// Optional build macro: ORGATE_PARITY_EN adds the registered parity_q signal.
//
// Signals:
//   a, b       [WIDTH-1:0]  operands (driven by master)
//   in_valid                marks a/b as a valid operation this cycle (master)
//   c          [WIDTH-1:0]  combinational a | b (slave)
//   c_q        [WIDTH-1:0]  registered a | b (slave)
//   out_valid               c_q and flags are valid (slave)
//   zero_q                  registered flag: result == 0 (slave)
//   ones_q                  registered flag: result == all ones (slave)
//   parity_q                registered XOR-reduction of result (slave, optional)
//
// Modports:
//   master -- operand source / result consumer
//   slave  -- the orgate unit itself
// ----------------------------------------------------------------------------
interface orgate_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             in_valid;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] c_q;
    logic             out_valid;
    logic             zero_q;
    logic             ones_q;
`ifdef ORGATE_PARITY_EN
    logic             parity_q;
`endif

    modport master (
        output a, b, in_valid,
        input  c, c_q, out_valid, zero_q, ones_q
`ifdef ORGATE_PARITY_EN
        , input parity_q
`endif
    );

    modport slave (
        input  a, b, in_valid,
        output c, c_q, out_valid, zero_q, ones_q
`ifdef ORGATE_PARITY_EN
        , output parity_q
`endif
    );
endinterface

// File: rtl/orgate.sv
// ----------------------------------------------------------------------------
// orgate -- parameterised bitwise-OR unit for the teacher-core datapath.
//
// Provides a zero-latency combinational result (c = a | b) for existing
// users, and a one-cycle-latency registered copy with zero/all-ones status
// flags and a valid bit for pipelined consumers. No backpressure: every
// in_valid cycle yields exactly one result on the following cycle.
//
// Optional build macro: ORGATE_PARITY_EN -- adds registered parity_q
// (XOR-reduction of the result), captured alongside c_q.
//
// Parameters:
//   WIDTH  operand/result width in bits, legal range 1..64 (default 32)
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (clears registered outputs only)
//   bus    orgate_if.slave: a, b, in_valid in; c, c_q, out_valid,
//          zero_q, ones_q (and parity_q when enabled) out
// ----------------------------------------------------------------------------
module orgate #(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      rst_n,
    orgate_if.slave   bus
);

    // ------------------------------------------------------------------
    // Combinational path: one OR per bit, no clock or reset involvement.
    // Plain '|' keeps standard X propagation (1|X = 1, 0|X = X).
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] or_comb;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_or_bit
            assign or_comb[gi] = bus.a[gi] | bus.b[gi];
        end
    endgenerate

    assign bus.c = or_comb;

    // ------------------------------------------------------------------
    // Registered path
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] c_q_reg;
    logic [WIDTH-1:0] c_q_next;
    logic             zero_q_reg;
    logic             zero_q_next;
    logic             ones_q_reg;
    logic             ones_q_next;
    logic             out_valid_reg;
    logic             out_valid_next;
`ifdef ORGATE_PARITY_EN
    logic             parity_q_reg;
    logic             parity_q_next;
`endif

    // Result and flags load only on a valid operation and otherwise hold;
    // out_valid simply tracks in_valid one cycle late.
    always_comb begin
        c_q_next       = c_q_reg;
        zero_q_next    = zero_q_reg;
        ones_q_next    = ones_q_reg;
        out_valid_next = bus.in_valid;
`ifdef ORGATE_PARITY_EN
        parity_q_next  = parity_q_reg;
`endif
        if (bus.in_valid) begin
            c_q_next    = or_comb;
            // Reductions span exactly WIDTH bits, so WIDTH=1 degenerates
            // to zero = ~c, ones = c without special casing.
            zero_q_next = ~|or_comb;
            ones_q_next = &or_comb;
`ifdef ORGATE_PARITY_EN
            parity_q_next = ^or_comb;
`endif
        end
    end

    // Asynchronous assert clears everything immediately, so a result that
    // was in flight when reset hit is dropped rather than emitted later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q_reg       <= '0;
            zero_q_reg    <= 1'b0;
            ones_q_reg    <= 1'b0;
            out_valid_reg <= 1'b0;
`ifdef ORGATE_PARITY_EN
            parity_q_reg  <= 1'b0;
`endif
        end else begin
            c_q_reg       <= c_q_next;
            zero_q_reg    <= zero_q_next;
            ones_q_reg    <= ones_q_next;
            out_valid_reg <= out_valid_next;
`ifdef ORGATE_PARITY_EN
            parity_q_reg  <= parity_q_next;
`endif
        end
    end

    assign bus.c_q       = c_q_reg;
    assign bus.zero_q    = zero_q_reg;
    assign bus.ones_q    = ones_q_reg;
    assign bus.out_valid = out_valid_reg;
`ifdef ORGATE_PARITY_EN
    assign bus.parity_q  = parity_q_reg;
`endif

endmodule

// File: tb/tb_orgate.sv
// ----------------------------------------------------------------------------
// tb_orgate -- self-checking bench for orgate.
// Three instances (WIDTH = 32, 8, 1) share clk/rst_n. A behavioural model
// computes expected values from the operational rules (OR, compare against
// zero / all-ones, popcount parity); a constant table covers the 32-bit
// directed vectors; hand sequences cover reset and narrow widths.
// ----------------------------------------------------------------------------
module tb_orgate;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    orgate_if #(.WIDTH(32)) bus32 ();
    orgate_if #(.WIDTH(8))  bus8  ();
    orgate_if #(.WIDTH(1))  bus1  ();

    orgate #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
    orgate #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
    orgate #(.WIDTH(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(bus1));

    int checks = 0;
    int errors = 0;
    int txn    = 0;

    // ---------------- reference model state ----------------
    int          widths [3] = '{32, 8, 1};
    logic [63:0] ma   [3];
    logic [63:0] mb   [3];
    logic        mv   [3];
    logic [63:0] m_cq [3];
    logic        m_ov [3];
    logic        m_z  [3];
    logic        m_o  [3];
    logic        m_p  [3];

    function automatic logic [63:0] wmask(int w);
        logic [63:0] all1;
        all1 = '1;
        return (w >= 64) ? all1 : ((64'd1 << w) - 64'd1);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_cq[i] = '0; m_ov[i] = 1'b0; m_z[i] = 1'b0; m_o[i] = 1'b0; m_p[i] = 1'b0;
        end
    endtask

    task automatic drive(input int idx, input logic [63:0] a, input logic [63:0] b, input logic v);
        ma[idx] = a & wmask(widths[idx]);
        mb[idx] = b & wmask(widths[idx]);
        mv[idx] = v;
        case (idx)
            0: begin bus32.a = a[31:0]; bus32.b = b[31:0]; bus32.in_valid = v; end
            1: begin bus8.a  = a[7:0];  bus8.b  = b[7:0];  bus8.in_valid  = v; end
            default: begin bus1.a = a[0:0]; bus1.b = b[0:0]; bus1.in_valid = v; end
        endcase
    endtask

    task automatic read(input int idx, output logic [63:0] c, output logic [63:0] cq,
                        output logic ov, output logic z, output logic o, output logic p);
        p = 1'b0;
        case (idx)
            0: begin
                c = {32'd0, bus32.c}; cq = {32'd0, bus32.c_q};
                ov = bus32.out_valid; z = bus32.zero_q; o = bus32.ones_q;
`ifdef ORGATE_PARITY_EN
                p = bus32.parity_q;
`endif
            end
            1: begin
                c = {56'd0, bus8.c}; cq = {56'd0, bus8.c_q};
                ov = bus8.out_valid; z = bus8.zero_q; o = bus8.ones_q;
`ifdef ORGATE_PARITY_EN
                p = bus8.parity_q;
`endif
            end
            default: begin
                c = {63'd0, bus1.c}; cq = {63'd0, bus1.c_q};
                ov = bus1.out_valid; z = bus1.zero_q; o = bus1.ones_q;
`ifdef ORGATE_PARITY_EN
                p = bus1.parity_q;
`endif
            end
        endcase
    endtask

    // Compare registered outputs of every instance against the model.
    task automatic check_regs(input string tag);
        logic [63:0] c, cq; logic ov, z, o, p;
        for (int i = 0; i < 3; i++) begin
            read(i, c, cq, ov, z, o, p);
            chk($sformatf("%s.w%0d.c_q", tag, widths[i]), cq, m_cq[i]);
            chk($sformatf("%s.w%0d.out_valid", tag, widths[i]), {63'd0, ov}, {63'd0, m_ov[i]});
            chk($sformatf("%s.w%0d.zero_q", tag, widths[i]), {63'd0, z}, {63'd0, m_z[i]});
            chk($sformatf("%s.w%0d.ones_q", tag, widths[i]), {63'd0, o}, {63'd0, m_o[i]});
`ifdef ORGATE_PARITY_EN
            chk($sformatf("%s.w%0d.parity_q", tag, widths[i]), {63'd0, p}, {63'd0, m_p[i]});
`endif
        end
    endtask

    task automatic check_comb(input string tag);
        logic [63:0] c, cq; logic ov, z, o, p;
        for (int i = 0; i < 3; i++) begin
            read(i, c, cq, ov, z, o, p);
            chk($sformatf("%s.w%0d.c", tag, widths[i]), c, ma[i] | mb[i]);
        end
    endtask

    // One clocked transaction: inputs already driven (away from the edge).
    task automatic step(input string tag);
        logic [63:0] res;
        #1;
        check_comb(tag);
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            if (mv[i]) begin
                res     = ma[i] | mb[i];
                m_cq[i] = res;
                m_z[i]  = (res == 64'd0);
                m_o[i]  = (res == wmask(widths[i]));
                m_p[i]  = ($countones(res) % 2) == 1;
            end
            m_ov[i] = mv[i];
        end
        #1;
        check_regs(tag);
        txn++;
        $display("txn %0d %s: a=%h b=%h v=%b c=%h c_q=%h ov=%b z=%b o=%b", txn, tag,
                 bus32.a, bus32.b, bus32.in_valid, bus32.c, bus32.c_q,
                 bus32.out_valid, bus32.zero_q, bus32.ones_q);
    endtask

    // ---------------- directed 32-bit table ----------------
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        v;
        logic [31:0] exp_c;
        logic [31:0] exp_cq;
        logic        exp_ov;
        logic        exp_z;
        logic        exp_o;
        logic        exp_p;
    } vec_t;

    vec_t vecs [7];

    initial begin
        vecs[0] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0};
        // 0x007FA509 has 13 set bits -> odd parity
        vecs[2] = '{32'h0000_0000, 32'h007F_A509, 1'b1, 32'h007F_A509, 32'h007F_A509, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0};
        // in_valid dropped: c tracks inputs, c_q and flags hold
        vecs[4] = '{32'h1234_5678, 32'h0000_0000, 1'b0, 32'h1234_5678, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h8000_0001, 32'h8000_0001, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{32'h0F0F_0000, 32'h0000_00F1, 1'b1, 32'h0F0F_00F1, 32'h0F0F_00F1, 1'b1, 1'b0, 1'b0, 1'b1};
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [63:0] c, cq; logic ov, z, o, p;

        // ---- reset state ----
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) drive(i, 64'd0, 64'd0, 1'b0);
        model_reset();
        #1;
        check_regs("reset");
        repeat (2) @(posedge clk);
        #1;
        check_regs("reset_hold");
        @(negedge clk);
        rst_n = 1'b1;
        step("release_idle");

        // ---- table-driven 32-bit vectors ----
        for (int k = 0; k < 7; k++) begin
            drive(0, {32'd0, vecs[k].a}, {32'd0, vecs[k].b}, vecs[k].v);
            drive(1, 64'd0, 64'd0, 1'b0);
            drive(2, 64'd0, 64'd0, 1'b0);
            step($sformatf("vec%0d", k));
            read(0, c, cq, ov, z, o, p);
            chk($sformatf("tbl%0d.c", k), c, {32'd0, vecs[k].exp_c});
            chk($sformatf("tbl%0d.c_q", k), cq, {32'd0, vecs[k].exp_cq});
            chk($sformatf("tbl%0d.out_valid", k), {63'd0, ov}, {63'd0, vecs[k].exp_ov});
            chk($sformatf("tbl%0d.zero_q", k), {63'd0, z}, {63'd0, vecs[k].exp_z});
            chk($sformatf("tbl%0d.ones_q", k), {63'd0, o}, {63'd0, vecs[k].exp_o});
`ifdef ORGATE_PARITY_EN
            chk($sformatf("tbl%0d.parity_q", k), {63'd0, p}, {63'd0, vecs[k].exp_p});
`endif
        end

        // ---- WIDTH=8 and WIDTH=1 boundaries ----
        drive(0, 64'd0, 64'd0, 1'b0);
        drive(1, 64'hA5, 64'h5A, 1'b1);
        drive(2, 64'd0, 64'd0, 1'b1);
        step("narrow1");
        read(1, c, cq, ov, z, o, p);
        chk("w8.A5|5A.c_q", cq, 64'hFF);
        chk("w8.A5|5A.ones_q", {63'd0, o}, 64'd1);
        read(2, c, cq, ov, z, o, p);
        chk("w1.0|0.zero_q", {63'd0, z}, 64'd1);
        chk("w1.0|0.ones_q", {63'd0, o}, 64'd0);

        drive(1, 64'h00, 64'h00, 1'b1);
        drive(2, 64'd1, 64'd0, 1'b1);
        step("narrow2");
        read(1, c, cq, ov, z, o, p);
        chk("w8.00|00.zero_q", {63'd0, z}, 64'd1);
        chk("w8.00|00.ones_q", {63'd0, o}, 64'd0);
        read(2, c, cq, ov, z, o, p);
        chk("w1.1|0.zero_q", {63'd0, z}, 64'd0);
        chk("w1.1|0.ones_q", {63'd0, o}, 64'd1);

        // ---- asynchronous reset mid-stream ----
        drive(0, 64'h0F0F_0000, 64'h0000_00F0, 1'b1);
        drive(1, 64'h3C, 64'h01, 1'b1);
        drive(2, 64'd1, 64'd1, 1'b1);
        step("pre_reset");
        read(0, c, cq, ov, z, o, p);
        chk("pre_reset.out_valid", {63'd0, ov}, 64'd1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_regs("async_reset");
        check_comb("async_reset");
        // in_valid still high across an edge held in reset: result discarded
        @(posedge clk);
        #1;
        check_regs("reset_discard");
        rst_n = 1'b1;
        #1;
        check_regs("after_release");
        step("first_capture");
        read(0, c, cq, ov, z, o, p);
        chk("first_capture.c_q", cq, 64'h0F0F_00F0);
        chk("first_capture.out_valid", {63'd0, ov}, 64'd1);

        // ---- randomized stimulus against the model ----
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < 3; i++) begin
                logic [63:0] ra, rb;
                int sel;
                ra  = {$urandom, $urandom};
                rb  = {$urandom, $urandom};
                sel = $urandom_range(0, 7);
                // bias some operands to hit the zero / all-ones flags
                if (sel == 0) begin ra = 64'd0; rb = 64'd0; end
                if (sel == 1) begin ra = '1; end
                if (sel == 2) begin rb = ~ra; end
                drive(i, ra, rb, ($urandom_range(0, 3) != 0));
            end
            step($sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
